// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   mem_size_t  : access size encoding on req_size (2'b11 is illegal, not enumerated)
//   mem_state_t : responder FSM states
//   lane_mask() : byte-lane write enables for a store of a given size/offset
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  // Lane i enables byte [8*i+7:8*i] of the addressed word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_B:  m = 4'b0001 << lo;
      SIZE_H:  m = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request/response bus between the CPU memory stage (master)
// and the data-memory responder (slave).
//   req_*  : valid/ready request channel, byte address, right-aligned wdata
//   resp_* : valid/ready response channel, load data and fault flag
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/load_align.sv
// Load data aligner: picks the byte/half lane out of a 32-bit word and
// sign- or zero-extends it. Word loads pass through untouched.
//   word_i     : full memory word
//   addr_i     : byte offset within the word
//   size_i     : access size (mem_size_t encoding; 2'b11 yields 0)
//   unsigned_i : zero-extend instead of sign-extend (byte/half only)
//   data_o     : extended 32-bit result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    data_o   = '0;
    byte_sel = word_i[8*addr_i +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_B:  data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SIZE_H:  data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      SIZE_W:  data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, commits the access against a 2**ADDR_WIDTH x 32-bit array, then
// holds the response until the requester takes it.
//   clk   : clock
//   reset : synchronous active-high reset (memory contents are kept)
//   bus   : slave side of the request/response bus
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2    // 1..15
) (
  input  logic     clk,
  input  logic     reset,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, commit;

  // Fields latched at accept time
  logic                  write_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  err_q;

  // Response registers
  logic [31:0] rdata_q;
  logic        rerr_q;

  logic [31:0] mem_q [DEPTH];

  logic                  req_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            wmask;
  logic [31:0]           wlanes;
  logic [31:0]           rd_word;
  logic [31:0]           load_val;

  // Fault check on the incoming request; latched together with the fields.
  always_comb begin
    req_err = (bus.req_size == 2'b11)
            | ((bus.req_size == SIZE_H) & bus.req_addr[0])
            | ((bus.req_size == SIZE_W) & (bus.req_addr[1:0] != 2'b00))
            | ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        cnt_d   = 4'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        commit  = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_err;
      end
      if (commit) begin
        rerr_q  <= err_q;
        rdata_q <= (write_q | err_q) ? '0 : load_val;
      end else if (state_q == RESP && bus.resp_ready) begin
        rdata_q <= '0;
        rerr_q  <= 1'b0;
      end
    end
  end

  // Store path: replicate right-aligned data onto every lane, mask selects.
  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  assign wmask    = lane_mask(size_q, addr_q[1:0]);
  // reset wins over a same-edge commit so a store still in WAIT is dropped
  assign mem_we   = commit & write_q & ~err_q & ~reset;

  always_comb begin
    case (size_q)
      SIZE_B:  wlanes = {4{wdata_q[7:0]}};
      SIZE_H:  wlanes = {2{wdata_q[15:0]}};
      default: wlanes = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem_q[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Load path
  assign rd_word = mem_q[word_idx];

  load_align u_align (
    .word_i     (rd_word),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_val)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = rerr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 3, 1) share the
// stimulus bus; sel routes handshakes to one of them. Expected responses
// come from a per-instance memory model and go through a scoreboard queue.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   sel;
  logic rst_all, rst_sel;
  logic        req_valid, req_write, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        rr_v [3];
  logic        rv_v [3];
  logic        re_v [3];
  logic [31:0] rd_v [3];
  logic        o_req_ready, o_resp_valid, o_resp_error;
  logic [31:0] o_resp_rdata;

  mem_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].req_valid    = req_valid & (sel == g);
    assign bus[g].resp_ready   = resp_ready & (sel == g);
    assign bus[g].req_write    = req_write;
    assign bus[g].req_addr     = req_addr;
    assign bus[g].req_wdata    = req_wdata;
    assign bus[g].req_size     = req_size;
    assign bus[g].req_unsigned = req_unsigned;
    assign rr_v[g] = bus[g].req_ready;
    assign rv_v[g] = bus[g].resp_valid;
    assign re_v[g] = bus[g].resp_error;
    assign rd_v[g] = bus[g].resp_rdata;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(g == 0 ? 2 : (g == 1 ? 3 : 1))) u_dut (
      .clk   (clk),
      .reset (rst_all | (rst_sel & (sel == g))),
      .bus   (bus[g])
    );
  end

  always_comb begin
    o_req_ready  = rr_v[sel];
    o_resp_valid = rv_v[sel];
    o_resp_error = re_v[sel];
    o_resp_rdata = rd_v[sel];
  end

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { bit w; logic [31:0] a; logic [31:0] d; logic [1:0] sz; bit u; } op_t;

  exp_t        sbq [$];
  logic [31:0] mdl [3][1024];
  int passed = 0;
  int total  = 0;

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : ((s == 1) ? 3 : 1);
  endfunction

  // Drives one access on the selected instance, pushes the model's expected
  // response, and returns what the DUT produced.
  task automatic issue(input op_t op, input int hold,
                       output logic [31:0] rd, output logic er, output int lat_o,
                       output bit stable, output logic rdy_after);
    exp_t        e;
    logic [9:0]  idx;
    logic [31:0] wd;
    logic [7:0]  bt;
    logic [15:0] hw;
    e.err   = (op.sz == 2'b11) || (op.sz == 2'b01 && op.a[0]) ||
              (op.sz == 2'b10 && op.a[1:0] != 2'b00) || (op.a[31:12] != 20'h0);
    e.rdata = 32'h0;
    idx     = op.a[11:2];
    if (!e.err) begin
      if (op.w) begin
        for (int b = 0; b < 4; b++) begin
          if (op.sz == 2'b10)
            mdl[sel][idx][8*b +: 8] = op.d[8*b +: 8];
          else if (op.sz == 2'b01 && (b / 2) == int'(op.a[1]))
            mdl[sel][idx][8*b +: 8] = op.d[8*(b % 2) +: 8];
          else if (op.sz == 2'b00 && b == int'(op.a[1:0]))
            mdl[sel][idx][8*b +: 8] = op.d[7:0];
        end
      end else begin
        wd = mdl[sel][idx];
        bt = wd[8*op.a[1:0] +: 8];
        hw = wd[16*op.a[1] +: 16];
        case (op.sz)
          2'b00:   e.rdata = op.u ? {24'h0, bt} : {{24{bt[7]}}, bt};
          2'b01:   e.rdata = op.u ? {16'h0, hw} : {{16{hw[15]}}, hw};
          default: e.rdata = wd;
        endcase
      end
    end
    sbq.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_write = op.w; req_addr = op.a;
    req_wdata = op.d; req_size = op.sz; req_unsigned = op.u;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat_o = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (o_resp_valid) begin lat_o = n; break; end
    end
    rd = o_resp_rdata; er = o_resp_error; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (o_resp_valid !== 1'b1 || o_resp_rdata !== rd || o_resp_error !== er ||
          o_req_ready !== 1'b0) stable = 1'b0;
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    rdy_after = o_req_ready;
  endtask

  task automatic test_reset();
    rst_all = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", o_req_ready); else passed++;
    total++; if (o_resp_valid !== 1'b0) $display("FAIL reset resp_valid: got %b want 0", o_resp_valid); else passed++;
    total++; if (o_resp_rdata !== 32'h0) $display("FAIL reset resp_rdata: got %h want 0", o_resp_rdata); else passed++;
    total++; if (o_resp_error !== 1'b0) $display("FAIL reset resp_error: got %b want 0", o_resp_error); else passed++;
    @(negedge clk) rst_all = 1'b0;
  endtask

  task automatic test_basic();
    op_t ops [2];
    logic [31:0] rd; logic er, ra; int lt; bit st; exp_t e;
    ops = '{'{1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0},
            '{1'b0, 32'h10, 32'h0,        2'b10, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 0, rd, er, lt, st, ra);
      e = sbq.pop_front();
      total++; if (lt !== lat_of(sel)) $display("FAIL basic[%0d] latency: got %0d want %0d", i, lt, lat_of(sel)); else passed++;
      total++; if (rd !== e.rdata) $display("FAIL basic[%0d] rdata: got %h want %h", i, rd, e.rdata); else passed++;
      total++; if (er !== e.err) $display("FAIL basic[%0d] error: got %b want %b", i, er, e.err); else passed++;
    end
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL basic LW 0x10: got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_byte();
    op_t ops [4];
    logic [31:0] rd; logic er, ra; int lt; bit st; exp_t e;
    ops = '{'{1'b1, 32'h13, 32'h80, 2'b00, 1'b0},
            '{1'b0, 32'h13, 32'h0,  2'b00, 1'b0},
            '{1'b0, 32'h13, 32'h0,  2'b00, 1'b1},
            '{1'b0, 32'h10, 32'h0,  2'b10, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 0, rd, er, lt, st, ra);
      e = sbq.pop_front();
      total++; if (lt !== lat_of(sel)) $display("FAIL byte[%0d] latency: got %0d want %0d", i, lt, lat_of(sel)); else passed++;
      total++; if (rd !== e.rdata) $display("FAIL byte[%0d] rdata: got %h want %h", i, rd, e.rdata); else passed++;
      total++; if (er !== e.err) $display("FAIL byte[%0d] error: got %b want %b", i, er, e.err); else passed++;
    end
  endtask

  task automatic test_half_err();
    op_t ops [6];
    logic [31:0] rd; logic er, ra; int lt; bit st; exp_t e;
    ops = '{'{1'b1, 32'h12, 32'h1234,     2'b01, 1'b0},
            '{1'b0, 32'h12, 32'h0,        2'b01, 1'b0},
            '{1'b0, 32'h11, 32'h0,        2'b01, 1'b0},
            '{1'b0, 32'h12, 32'h0,        2'b10, 1'b0},
            '{1'b1, 32'h12, 32'hFFFFFFFF, 2'b10, 1'b0},
            '{1'b0, 32'h10, 32'h0,        2'b10, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], 0, rd, er, lt, st, ra);
      e = sbq.pop_front();
      total++; if (rd !== e.rdata) $display("FAIL half[%0d] rdata: got %h want %h", i, rd, e.rdata); else passed++;
      total++; if (er !== e.err) $display("FAIL half[%0d] error: got %b want %b", i, er, e.err); else passed++;
    end
  endtask

  task automatic test_range();
    op_t ops [7];
    logic [31:0] rd; logic er, ra; int lt; bit st; exp_t e;
    ops = '{'{1'b1, 32'h0,    32'hCAFEF00D, 2'b10, 1'b0},
            '{1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0},
            '{1'b0, 32'h1000, 32'h0,        2'b10, 1'b0},
            '{1'b0, 32'h0,    32'h0,        2'b10, 1'b0},
            '{1'b0, 32'h10,   32'h0,        2'b11, 1'b0},
            '{1'b1, 32'h10,   32'h0,        2'b11, 1'b0},
            '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], 0, rd, er, lt, st, ra);
      e = sbq.pop_front();
      total++; if (rd !== e.rdata) $display("FAIL range[%0d] rdata: got %h want %h", i, rd, e.rdata); else passed++;
      total++; if (er !== e.err) $display("FAIL range[%0d] error: got %b want %b", i, er, e.err); else passed++;
    end
  endtask

  task automatic test_hold();
    op_t op;
    logic [31:0] rd; logic er, ra; int lt; bit st; exp_t e;
    op = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0};
    issue(op, 5, rd, er, lt, st, ra);
    e = sbq.pop_front();
    total++; if (st !== 1'b1) $display("FAIL hold stability: got %b want 1", st); else passed++;
    total++; if (ra !== 1'b1) $display("FAIL hold req_ready after take: got %b want 1", ra); else passed++;
    total++; if (rd !== e.rdata) $display("FAIL hold rdata: got %h want %h", rd, e.rdata); else passed++;
  endtask

  // Store aborted by reset while in WAIT must leave memory untouched.
  task automatic test_reset_wait(input int s);
    op_t op;
    logic [31:0] rd; logic er, ra; int lt; bit st; exp_t e;
    sel = s;
    op = '{1'b1, 32'h20, 32'h11112222, 2'b10, 1'b0};
    issue(op, 0, rd, er, lt, st, ra);
    e = sbq.pop_front();
    total++; if (er !== e.err) $display("FAIL rstwait%0d prefill error: got %b want %b", s, er, e.err); else passed++;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_size = 2'b10;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk) rst_sel = 1'b1;
    @(posedge clk); #1;
    total++; if (o_resp_valid !== 1'b0) $display("FAIL rstwait%0d resp_valid: got %b want 0", s, o_resp_valid); else passed++;
    total++; if (o_req_ready !== 1'b1) $display("FAIL rstwait%0d req_ready: got %b want 1", s, o_req_ready); else passed++;
    @(negedge clk) rst_sel = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (o_resp_valid !== 1'b0) $display("FAIL rstwait%0d late resp_valid: got %b want 0", s, o_resp_valid); else passed++;
    op = '{1'b0, 32'h20, 32'h0, 2'b10, 1'b0};
    issue(op, 0, rd, er, lt, st, ra);
    e = sbq.pop_front();
    total++; if (lt !== lat_of(s)) $display("FAIL rstwait%0d latency: got %0d want %0d", s, lt, lat_of(s)); else passed++;
    total++; if (rd !== e.rdata) $display("FAIL rstwait%0d rdata: got %h want %h", s, rd, e.rdata); else passed++;
  endtask

  initial begin
    sel = 0; rst_sel = 1'b0; rst_all = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_byte();
    test_half_err();
    test_range();
    test_hold();
    test_reset_wait(1);
    test_reset_wait(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
